// File: rtl/norm_feed_pkg.sv
// rtl/norm_feed_pkg.sv - shared output width, clamp limits and FSM state type for norm_feed_accum
package norm_feed_pkg;

  localparam int OUT_W = 16;
  localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/norm_feed_lane.sv
// rtl/norm_feed_lane.sv - one channel: accumulator, window-end add and 16-bit reduction
// Reduction clamps when NORM_FEED_SAT_EN is defined, otherwise wraps to the 16 LSBs.
module norm_feed_lane
  import norm_feed_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int ACC_W = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    accept_i,
  input  logic                    last_i,
  input  logic signed [IN_W-1:0]  sample_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    sat_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic signed [OUT_W-1:0] dout_q, dout_d, red;
  logic                    sat_q, sat_d, red_sat;

  assign sum = acc_q + ACC_W'(sample_i);

`ifdef NORM_FEED_SAT_EN
  // One guard bit above OUT_W keeps the overflow slice legal for narrow accumulators.
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  logic signed [EXT_W-1:0] sum_ext;
  logic                    ovf;

  assign sum_ext = EXT_W'(sum);
  assign ovf     = (sum_ext[EXT_W-1:OUT_W-1] != {(EXT_W-OUT_W+1){sum_ext[EXT_W-1]}});
  assign red     = ovf ? (sum_ext[EXT_W-1] ? SAT_MIN : SAT_MAX) : sum_ext[OUT_W-1:0];
  assign red_sat = ovf;
`else
  assign red     = OUT_W'(sum);
  assign red_sat = 1'b0;
`endif

  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    sat_d  = sat_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (accept_i) begin
      if (last_i) begin
        acc_d  = '0;
        dout_d = red;
        sat_d  = red_sat;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout_o = dout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/norm_feed_accum.sv
// rtl/norm_feed_accum.sv - windowed two-channel accumulator feeding a normalizer (option: NORM_FEED_SAT_EN)
module norm_feed_accum
  import norm_feed_pkg::*;
#(
  parameter int WIN  = 8,
  parameter int IN_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_1,
  input  logic signed [IN_W-1:0] in_2,
  output logic                   nd,
  output logic signed [15:0]     dout_1,
  output logic signed [15:0]     dout_2,
  output logic                   sat_flag
);

  localparam int CNT_W = $clog2(WIN);
  localparam int ACC_W = IN_W + CNT_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nd_q;
  logic             accept, last;
  logic             sat_1, sat_2;

  assign accept = in_valid & ~clr;
  assign last   = accept & (cnt_q == CNT_W'(WIN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) state_d = ACC;
      ACC:  if (clr || last) state_d = IDLE;
    endcase
    if (clr || last) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // nd is registered from the window-end cycle, so a clr arriving one cycle later cannot cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nd_q    <= last;
    end
  end

  norm_feed_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .accept_i (accept),
    .last_i   (last),
    .sample_i (in_1),
    .dout_o   (dout_1),
    .sat_o    (sat_1)
  );

  norm_feed_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .accept_i (accept),
    .last_i   (last),
    .sample_i (in_2),
    .dout_o   (dout_2),
    .sat_o    (sat_2)
  );

  assign nd       = nd_q;
  assign sat_flag = sat_1 | sat_2;

endmodule

// File: tb/tb_norm_feed_accum.sv
// tb/tb_norm_feed_accum.sv - directed vector bench for norm_feed_accum (WIN=8/IN_W=12 and WIN=4/IN_W=16)
module tb_norm_feed_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               a_v = 1'b0, a_c = 1'b0;
  logic signed [11:0] a_i1 = '0, a_i2 = '0;
  logic               a_nd, a_sat;
  logic signed [15:0] a_d1, a_d2;

  logic               b_v = 1'b0, b_c = 1'b0;
  logic signed [15:0] b_i1 = '0, b_i2 = '0;
  logic               b_nd, b_sat;
  logic signed [15:0] b_d1, b_d2;

  norm_feed_accum #(.WIN(8), .IN_W(12)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_c), .in_valid(a_v), .in_1(a_i1), .in_2(a_i2),
    .nd(a_nd), .dout_1(a_d1), .dout_2(a_d2), .sat_flag(a_sat)
  );

  norm_feed_accum #(.WIN(4), .IN_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_c), .in_valid(b_v), .in_1(b_i1), .in_2(b_i2),
    .nd(b_nd), .dout_1(b_d1), .dout_2(b_d2), .sat_flag(b_sat)
  );

  typedef struct {
    logic v;
    logic c;
    int   i1;
    int   i2;
    logic nd;
    int   d1;
    int   d2;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic c, input int i1, input int i2,
                     input logic nd, input int d1, input int d2);
    vec_t r;
    r.v = v; r.c = c; r.i1 = i1; r.i2 = i2; r.nd = nd; r.d1 = d1; r.d2 = d2;
    vecs.push_back(r);
  endtask

  task automatic step_a(input logic v, input logic c, input int i1, input int i2);
    a_v = v; a_c = c; a_i1 = 12'(i1); a_i2 = 12'(i2);
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input int i1, input int i2);
    b_v = v; b_c = 1'b0; b_i1 = 16'(i1); b_i2 = 16'(i2);
    @(posedge clk); #1;
  endtask

  initial begin
    // Window of +3/-2, then two back-to-back windows with distinct values.
    for (int k = 0; k < 8; k++) add(1, 0, 3, -2, k == 7, (k == 7) ? 24 : 0, (k == 7) ? -16 : 0);
    for (int k = 0; k < 8; k++) add(1, 0, k + 1, -1, k == 7, (k == 7) ? 36 : 24, (k == 7) ? -8 : -16);
    for (int k = 0; k < 8; k++) add(1, 0, 10, 7, k == 7, (k == 7) ? 80 : 36, (k == 7) ? 56 : -8);
    // Five samples then clr (sample on the clr cycle dropped), then eight ones.
    for (int k = 0; k < 5; k++) add(1, 0, 100, 100, 0, 80, 56);
    add(1, 1, 50, 50, 0, 80, 56);
    for (int k = 0; k < 8; k++) add(1, 0, 1, -1, k == 7, (k == 7) ? 8 : 80, (k == 7) ? -8 : 56);
    // in_valid toggling; idle-cycle data must be ignored.
    for (int k = 0; k < 15; k++)
      add((k % 2) == 0, 0, ((k % 2) == 0) ? 2 : 99, ((k % 2) == 0) ? -3 : 99,
          k == 14, (k == 14) ? 16 : 8, (k == 14) ? -24 : -8);

    @(posedge clk); @(posedge clk); #1;
    chk("reset a_nd", int'(a_nd), 0);
    chk("reset a_d1", a_d1, 0);
    chk("reset a_d2", a_d2, 0);
    chk("reset a_sat", int'(a_sat), 0);
    chk("reset b_nd", int'(b_nd), 0);
    chk("reset b_d1", b_d1, 0);
    chk("reset b_sat", int'(b_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].v, vecs[i].c, vecs[i].i1, vecs[i].i2);
      chk($sformatf("vec%0d nd", i), int'(a_nd), int'(vecs[i].nd));
      chk($sformatf("vec%0d d1", i), a_d1, vecs[i].d1);
      chk($sformatf("vec%0d d2", i), a_d2, vecs[i].d2);
      chk($sformatf("vec%0d sat", i), int'(a_sat), 0);
    end

    // clr in the cycle right after the window-end sample must not cancel nd.
    for (int k = 0; k < 8; k++) step_a(1, 0, 5, 5);
    chk("clrnd nd pre", int'(a_nd), 1);
    a_c = 1'b1; a_v = 1'b1; a_i1 = 12'(9);
    #1;
    chk("clrnd nd during clr", int'(a_nd), 1);
    chk("clrnd d1 during clr", a_d1, 40);
    @(posedge clk); #1;
    chk("clrnd nd after", int'(a_nd), 0);
    chk("clrnd d1 held", a_d1, 40);
    chk("clrnd d2 held", a_d2, 40);

    // Asynchronous reset mid-window discards the partial sum.
    for (int k = 0; k < 3; k++) step_a(1, 0, 7, 7);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst a_nd", int'(a_nd), 0);
    chk("rst a_d1", a_d1, 0);
    chk("rst a_d2", a_d2, 0);
    chk("rst a_sat", int'(a_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step_a(1, 0, 4, -5);
      chk($sformatf("postrst nd k%0d", k), int'(a_nd), (k == 7) ? 1 : 0);
    end
    chk("postrst d1", a_d1, 32);
    chk("postrst d2", a_d2, -40);
    step_a(0, 0, 0, 0);
    chk("postrst nd drop", int'(a_nd), 0);

    // Wide-input instance: clamp vs wrap at the 16-bit boundary.
    for (int k = 0; k < 4; k++) begin
      step_b(1, 30000, -30000);
      chk($sformatf("sat nd k%0d", k), int'(b_nd), (k == 3) ? 1 : 0);
    end
`ifdef NORM_FEED_SAT_EN
    chk("sat d1", b_d1, 32767);
    chk("sat d2", b_d2, -32768);
    chk("sat flag", int'(b_sat), 1);
`else
    chk("wrap d1", b_d1, -11072);
    chk("wrap d2", b_d2, 11072);
    chk("wrap flag", int'(b_sat), 0);
`endif
    for (int k = 0; k < 4; k++) step_b(1, 1000, -1000);
    chk("nosat nd", int'(b_nd), 1);
    chk("nosat d1", b_d1, 4000);
    chk("nosat d2", b_d2, -4000);
    chk("nosat flag", int'(b_sat), 0);
    step_b(0, 0, 0);
    chk("nosat nd drop", int'(b_nd), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
